pwm_softstart: RTL and testbench
================================

PWM_SOFTSTART -- requirements
Module: pwm_softstart

Interface
REQ-001 SHALL have parameter W, default 8: width of period, duty, step and counter values.
REQ-002 SHALL have port clock  in  1  rising-edge clock.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-004 SHALL have port cfg_valid  in  1  configuration request.
REQ-005 SHALL have port cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready.
REQ-006 SHALL have port cfg_T  in  W  requested PWM period (terminal count).
REQ-007 SHALL have port cfg_target  in  W  requested final duty.
REQ-008 SHALL have port cfg_step  in  W  duty increment/decrement per PWM period; 0 = jump.
REQ-009 SHALL have port stop  in  1  request ramp-down to zero and shutdown.
REQ-010 SHALL have port pwm_cont  in  W  counter value fed back from the downstream PWM.
REQ-011 SHALL have port pwm_inc  out  1  PWM enable.
REQ-012 SHALL have port pwm_T  out  W  period to PWM.
REQ-013 SHALL have port pwm_duty  out  W  duty to PWM.
REQ-014 SHALL have port state  out  2  FSM state: 0 IDLE, 1 RAMP_UP, 2 HOLD, 3 RAMP_DOWN.
REQ-015 SHALL have port done  out  1  one-cycle pulse on entry to HOLD.

Function
REQ-016 SHALL define boundary = pwm_inc && (pwm_cont == pwm_T), evaluated combinationally each cycle.
REQ-017 SHALL drive cfg_ready = (state IDLE or HOLD) && !stop && reset; cfg_ready SHALL be 0 in RAMP_UP and RAMP_DOWN.
REQ-018 SHALL clamp the accepted target to min(cfg_target, cfg_T) at acceptance.
REQ-019 In IDLE, on accept: next cycle pwm_T = cfg_T, pwm_duty = 0, pwm_inc = 1, state = RAMP_UP; target and step latched.
REQ-020 In RAMP_UP, at a boundary: pwm_duty <= min(pwm_duty + step, target), sum computed at W+1 bits (no wrap); step 0 SHALL load target directly.
REQ-021 In RAMP_UP, when the updated duty equals target (including target 0 on the first boundary): state <= HOLD, done pulses for that one cycle.
REQ-022 In RAMP_DOWN, at a boundary: pwm_duty <= max(pwm_duty - step, target) with saturation at 0 (no wrap); step 0 SHALL load target directly.
REQ-023 In RAMP_DOWN, when the updated duty equals target: target nonzero -> HOLD with done pulse; target 0 -> IDLE.
REQ-024 Entering IDLE from RAMP_DOWN SHALL clear pwm_inc, and pwm_duty and pwm_T SHALL hold their values until the next accept.
REQ-025 In HOLD, on accept: new T, target and step SHALL be held pending; pwm outputs unchanged until the next boundary.
REQ-026 At the first boundary with a pending configuration: pwm_T <= pending T, pwm_duty <= min(pwm_duty, pending T); state <= RAMP_UP if target > that duty, RAMP_DOWN if target < that duty, else HOLD with done pulse.
REQ-027 stop asserted in RAMP_UP, HOLD or RAMP_DOWN SHALL set target = 0, discard any pending configuration, and move state to RAMP_DOWN next cycle; stop in IDLE SHALL be ignored.
REQ-028 stop and cfg_valid in the same cycle: stop SHALL win; no accept occurs.
REQ-029 pwm_duty and pwm_T SHALL change only on IDLE accept or in the cycle after a boundary.
REQ-030 Invariant: pwm_duty <= pwm_T at all times out of reset.
REQ-031 Invariant: done SHALL never be high for two consecutive cycles.

Reset
REQ-032 reset low at a clock edge SHALL force state IDLE, pwm_inc 0, pwm_T 0, pwm_duty 0, done 0, pending cleared, target 0, step 0.
REQ-033 Reset asserted mid-ramp SHALL take effect on the next edge regardless of boundary, stop or cfg_valid.

Verification
REQ-034 Reset, then cfg T=9 target=6 step=2 -> pwm_inc=1, duty 0 then 2, 4, 6 after successive boundaries; done pulse once; state HOLD.
REQ-035 cfg T=9 target=20 step=3 -> target clamped to 9; duty 0, 3, 6, 9; HOLD.
REQ-036 cfg T=15 target=10 step=0 -> duty 10 after first boundary; HOLD with done.
REQ-037 In HOLD at duty 6, stop with step 4 -> RAMP_DOWN; duty 2, then 0; state IDLE and pwm_inc=0 after that boundary.
REQ-038 In HOLD at T=9 duty=6, cfg T=5 target=3 step=1 -> at next boundary pwm_T=5, duty 5; then 4, 3; HOLD with done.
REQ-039 reset low during RAMP_UP at duty 4 -> next cycle all outputs 0, state IDLE, cfg_ready 0 while reset low.

Source files
------------

// File: rtl/pwm_softstart.sv
// Soft-start supervisor for a downstream PWM: ramps duty toward a target one step per PWM period,
// holds it, retunes on request and ramps to zero on stop.
module pwm_softstart #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_T,
  input  logic [W-1:0] cfg_target,
  input  logic [W-1:0] cfg_step,
  input  logic         stop,
  input  logic [W-1:0] pwm_cont,
  output logic         pwm_inc,
  output logic [W-1:0] pwm_T,
  output logic [W-1:0] pwm_duty,
  output logic [1:0]   state,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t       cur, nxt;
  logic [W-1:0] target, step, pend_T, pend_target, pend_step;
  logic         pend_valid;

  logic         inc_n, done_n, pend_valid_n;
  logic [W-1:0] T_n, duty_n, target_n, step_n, pend_T_n, pend_target_n, pend_step_n;

  logic         boundary, accept;
  logic [W-1:0] cfg_clamped, eff_target, up_duty, dn_diff, dn_duty, hold_duty;
  logic [W:0]   up_sum;

  assign boundary    = pwm_inc && (pwm_cont == pwm_T);
  assign cfg_ready   = ((cur == IDLE) || (cur == HOLD)) && !stop && reset;
  assign accept      = cfg_valid && cfg_ready;
  assign cfg_clamped = (cfg_target > cfg_T) ? cfg_T : cfg_target;
  assign state       = cur;

  // A stop seen during a ramp-down boundary steers that same boundary toward zero.
  assign eff_target  = stop ? '0 : target;

  // Ramp arithmetic: the sum gets a carry bit and the difference saturates, so neither can wrap.
  assign up_sum    = {1'b0, pwm_duty} + {1'b0, step};
  assign up_duty   = (step == '0) ? target :
                     (up_sum > {1'b0, target}) ? target : up_sum[W-1:0];
  assign dn_diff   = (pwm_duty > step) ? (pwm_duty - step) : '0;
  assign dn_duty   = (step == '0) ? eff_target :
                     (dn_diff < eff_target) ? eff_target : dn_diff;
  assign hold_duty = (pwm_duty > pend_T) ? pend_T : pwm_duty;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cur         <= IDLE;
      pwm_inc     <= 1'b0;
      pwm_T       <= '0;
      pwm_duty    <= '0;
      done        <= 1'b0;
      target      <= '0;
      step        <= '0;
      pend_valid  <= 1'b0;
      pend_T      <= '0;
      pend_target <= '0;
      pend_step   <= '0;
    end else begin
      cur         <= nxt;
      pwm_inc     <= inc_n;
      pwm_T       <= T_n;
      pwm_duty    <= duty_n;
      done        <= done_n;
      target      <= target_n;
      step        <= step_n;
      pend_valid  <= pend_valid_n;
      pend_T      <= pend_T_n;
      pend_target <= pend_target_n;
      pend_step   <= pend_step_n;
    end
  end

  always_comb begin
    nxt           = cur;
    inc_n         = pwm_inc;
    T_n           = pwm_T;
    duty_n        = pwm_duty;
    done_n        = 1'b0;
    target_n      = target;
    step_n        = step;
    pend_valid_n  = pend_valid;
    pend_T_n      = pend_T;
    pend_target_n = pend_target;
    pend_step_n   = pend_step;

    case (cur)
      IDLE: begin
        if (accept) begin
          T_n          = cfg_T;
          duty_n       = '0;
          inc_n        = 1'b1;
          target_n     = cfg_clamped;
          step_n       = cfg_step;
          pend_valid_n = 1'b0;
          nxt          = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (stop) begin
          target_n     = '0;
          pend_valid_n = 1'b0;
          nxt          = RAMP_DOWN;
        end else if (boundary) begin
          duty_n = up_duty;
          if (up_duty == target) begin
            nxt    = HOLD;
            done_n = 1'b1;
          end
        end
      end
      HOLD: begin
        if (stop) begin
          target_n     = '0;
          pend_valid_n = 1'b0;
          nxt          = RAMP_DOWN;
        end else if (boundary && pend_valid) begin
          T_n          = pend_T;
          duty_n       = hold_duty;
          target_n     = pend_target;
          step_n       = pend_step;
          pend_valid_n = 1'b0;
          if (pend_target > hold_duty) begin
            nxt = RAMP_UP;
          end else if (pend_target < hold_duty) begin
            nxt = RAMP_DOWN;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      RAMP_DOWN: begin
        if (stop) begin
          target_n     = '0;
          pend_valid_n = 1'b0;
        end
        if (boundary) begin
          duty_n = dn_duty;
          if (dn_duty == eff_target) begin
            if (eff_target != '0) begin
              nxt    = HOLD;
              done_n = 1'b1;
            end else begin
              nxt          = IDLE;
              inc_n        = 1'b0;
              pend_valid_n = 1'b0;
            end
          end
        end
      end
      default: nxt = IDLE;
    endcase

    // A retune accepted while holding waits for a period boundary in HOLD.
    if (accept && (cur == HOLD)) begin
      pend_valid_n  = 1'b1;
      pend_T_n      = cfg_T;
      pend_target_n = cfg_clamped;
      pend_step_n   = cfg_step;
    end
  end

endmodule

// File: tb/tb_pwm_softstart.sv
// Self-checking bench for pwm_softstart: directed ramp scenarios with literal expectations,
// then randomized traffic compared every cycle against an integer behavioural model.
module tb_pwm_softstart;

  localparam int W      = 8;
  localparam int S_IDLE = 0;
  localparam int S_UP   = 1;
  localparam int S_HOLD = 2;
  localparam int S_DOWN = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [W-1:0] cfg_T = '0, cfg_target = '0, cfg_step = '0;
  logic         stop = 1'b0;
  logic [W-1:0] pwm_cont = '0;
  logic         pwm_inc;
  logic [W-1:0] pwm_T, pwm_duty;
  logic [1:0]   state;
  logic         done;

  always #5 clock = ~clock;

  pwm_softstart #(.W(W)) dut (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_T(cfg_T), .cfg_target(cfg_target), .cfg_step(cfg_step), .stop(stop),
    .pwm_cont(pwm_cont), .pwm_inc(pwm_inc), .pwm_T(pwm_T), .pwm_duty(pwm_duty),
    .state(state), .done(done)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: current register contents as plain integers.
  int m_state = 0, m_inc = 0, m_T = 0, m_duty = 0, m_done = 0, m_target = 0, m_step = 0;
  int m_pv = 0, m_pT = 0, m_ptgt = 0, m_pstep = 0;

  int pc = 0;
  bit jitter = 0;
  int hist[$];
  bit hist_en = 0;
  int done_cnt = 0;
  int s_state, s_inc, s_T, s_duty, s_done, s_rdy;
  bit prev_done = 0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic expect_eq(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_output(input int exp_rdy);
    s_state = int'(state);
    s_inc   = int'(pwm_inc);
    s_T     = int'(pwm_T);
    s_duty  = int'(pwm_duty);
    s_done  = int'(done);
    s_rdy   = int'(cfg_ready);
    expect_eq("state", s_state, m_state);
    expect_eq("pwm_inc", s_inc, m_inc);
    expect_eq("pwm_T", s_T, m_T);
    expect_eq("pwm_duty", s_duty, m_duty);
    expect_eq("done", s_done, m_done);
    expect_eq("cfg_ready", s_rdy, exp_rdy);
    expect_eq("duty_le_T", int'(s_duty <= s_T), 1);
    expect_eq("done_twice", int'(prev_done && s_done != 0), 0);
    prev_done = (s_done != 0);
    if (hist_en) begin
      if (hist.size() == 0 || hist[$] != s_duty) hist.push_back(s_duty);
      done_cnt += s_done;
    end
  endtask

  task automatic model_step(input bit rst, input bit v, input int cT, input int ctgt,
                            input int cstep, input bit stp, input int cont);
    bit bnd, rdy, acc;
    bnd = (m_inc != 0) && (cont == m_T);
    rdy = (m_state == S_IDLE || m_state == S_HOLD) && !stp && rst;
    acc = v && rdy;
    if (!rst) begin
      m_state = S_IDLE; m_inc = 0; m_T = 0; m_duty = 0; m_done = 0;
      m_target = 0; m_step = 0; m_pv = 0; m_pT = 0; m_ptgt = 0; m_pstep = 0;
      return;
    end
    m_done = 0;
    if (stp && m_state != S_IDLE) begin
      m_target = 0;
      m_pv = 0;
      if (m_state != S_DOWN) begin
        m_state = S_DOWN;
        return;
      end
    end
    case (m_state)
      S_IDLE: if (acc) begin
        m_T = cT; m_duty = 0; m_inc = 1; m_target = imin(ctgt, cT); m_step = cstep;
        m_pv = 0; m_state = S_UP;
      end
      S_UP: if (bnd) begin
        m_duty = (m_step == 0) ? m_target : imin(m_duty + m_step, m_target);
        if (m_duty == m_target) begin m_state = S_HOLD; m_done = 1; end
      end
      S_HOLD: begin
        if (bnd && m_pv != 0) begin
          m_T = m_pT; m_duty = imin(m_duty, m_pT); m_target = m_ptgt; m_step = m_pstep; m_pv = 0;
          if (m_target > m_duty) m_state = S_UP;
          else if (m_target < m_duty) m_state = S_DOWN;
          else m_done = 1;
        end
        if (acc) begin m_pv = 1; m_pT = cT; m_ptgt = imin(ctgt, cT); m_pstep = cstep; end
      end
      default: if (bnd) begin
        m_duty = (m_step == 0) ? m_target : imax(m_duty - m_step, m_target);
        if (m_duty == m_target) begin
          if (m_target != 0) begin m_state = S_HOLD; m_done = 1; end
          else begin m_state = S_IDLE; m_inc = 0; m_pv = 0; end
        end
      end
    endcase
  endtask

  // One clock cycle: drive at the falling edge, check, advance the model, then clock.
  task automatic apply_stimulus(input bit rst, input bit v, input int cT, input int ctgt,
                                input int cstep, input bit stp);
    int cont;
    int exp_rdy;
    cont = (jitter && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : pc;
    reset      = rst;
    cfg_valid  = v;
    cfg_T      = W'(cT);
    cfg_target = W'(ctgt);
    cfg_step   = W'(cstep);
    stop       = stp;
    pwm_cont   = W'(cont);
    #1;
    exp_rdy = int'((m_state == S_IDLE || m_state == S_HOLD) && !stp && rst);
    check_output(exp_rdy);
    model_step(rst, v, cT, ctgt, cstep, stp, cont);
    pc = (m_inc != 0) ? ((pc >= m_T) ? 0 : pc + 1) : 0;
    @(posedge clock);
    @(negedge clock);
  endtask

  // kind 0: wait for state == value; 1: wait for done; 2: wait for duty == value.
  task automatic run_until(input string name, input int kind, input int value, input int maxc);
    int n;
    bit hit;
    n = 0;
    hit = 0;
    while (!hit && n < maxc) begin
      apply_stimulus(1, 0, 0, 0, 0, 0);
      n++;
      hit = (kind == 0) ? (s_state == value) : (kind == 1) ? (s_done != 0) : (s_duty == value);
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: got no event after %0d cycles, expected kind %0d value %0d",
               name, maxc, kind, value);
    end
  endtask

  task automatic check_hist(input string name, input int n, input int e0, input int e1,
                            input int e2, input int e3);
    int e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    expect_eq({name, "_len"}, hist.size(), n);
    for (int i = 0; i < n; i++)
      if (i < hist.size()) expect_eq({name, "_seq"}, hist[i], e[i]);
  endtask

  task automatic do_reset();
    apply_stimulus(0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    hist.delete();
    done_cnt = 0;
    hist_en = 1;
  endtask

  initial begin
    @(posedge clock);
    @(negedge clock);

    do_reset();
    expect_eq("reset_state", s_state, S_IDLE);
    expect_eq("reset_duty", s_duty, 0);

    // Basic ramp 0,2,4,6.
    do_reset();
    apply_stimulus(1, 1, 9, 6, 2, 0);
    run_until("ramp_basic", 0, S_HOLD, 200);
    check_hist("ramp_basic", 4, 0, 2, 4, 6);
    expect_eq("ramp_basic_done", done_cnt, 1);
    expect_eq("ramp_basic_inc", s_inc, 1);

    // Target above period is clamped to the period.
    do_reset();
    apply_stimulus(1, 1, 9, 20, 3, 0);
    run_until("clamp", 0, S_HOLD, 200);
    check_hist("clamp", 4, 0, 3, 6, 9);
    expect_eq("clamp_T", s_T, 9);

    // Step 0 jumps straight to the target.
    do_reset();
    apply_stimulus(1, 1, 15, 10, 0, 0);
    run_until("jump", 0, S_HOLD, 200);
    check_hist("jump", 2, 0, 10, 0, 0);
    expect_eq("jump_done", done_cnt, 1);

    // Stop from HOLD (with a simultaneous config that must lose) ramps down to IDLE.
    do_reset();
    apply_stimulus(1, 1, 9, 6, 4, 0);
    run_until("stop_up", 0, S_HOLD, 200);
    hist.delete();
    apply_stimulus(1, 1, 3, 3, 3, 1);
    run_until("stop_down", 0, S_IDLE, 200);
    check_hist("stop", 3, 6, 2, 0, 0);
    expect_eq("stop_inc", s_inc, 0);

    // Retune while holding: shorter period, lower target.
    do_reset();
    apply_stimulus(1, 1, 9, 6, 2, 0);
    run_until("retune_up", 0, S_HOLD, 200);
    hist.delete();
    done_cnt = 0;
    apply_stimulus(1, 1, 5, 3, 1, 0);
    run_until("retune", 1, 0, 200);
    check_hist("retune", 4, 6, 5, 4, 3);
    expect_eq("retune_T", s_T, 5);
    expect_eq("retune_state", s_state, S_HOLD);
    expect_eq("retune_done", done_cnt, 1);

    // Reset in the middle of a ramp.
    do_reset();
    apply_stimulus(1, 1, 9, 6, 2, 0);
    run_until("midreset", 2, 4, 200);
    apply_stimulus(0, 1, 9, 6, 2, 0);
    expect_eq("midreset_rdy", s_rdy, 0);
    apply_stimulus(0, 1, 9, 6, 2, 0);
    expect_eq("midreset_state", s_state, S_IDLE);
    expect_eq("midreset_inc", s_inc, 0);
    expect_eq("midreset_T", s_T, 0);
    expect_eq("midreset_duty", s_duty, 0);
    expect_eq("midreset_rdy2", s_rdy, 0);
    hist_en = 0;

    // Randomized traffic, including large periods/steps to exercise saturation.
    jitter = 1;
    for (int i = 0; i < 5000; i++) begin
      int r, cT, ctgt, cstep;
      r = $urandom_range(0, 99);
      cT    = ($urandom_range(0, 7) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 20);
      ctgt  = ($urandom_range(0, 7) == 0) ? $urandom_range(150, 255) : $urandom_range(0, 25);
      cstep = ($urandom_range(0, 7) == 0) ? $urandom_range(100, 255) : $urandom_range(0, 6);
      apply_stimulus(!(r < 2), ($urandom_range(0, 9) < 4), cT, ctgt, cstep, (r >= 2 && r < 5));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
